// File: rtl/traffic_light_pkg.sv
// Shared types for the single-approach traffic-light controller: state encoding
// and the state-to-lamp decode used by the top level.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    GREEN   = 3'd0,
    BLK_OFF = 3'd1,
    BLK_ON  = 3'd2,
    YELLOW  = 3'd3,
    RED     = 3'd4,
    FL_ON   = 3'd5,
    FL_OFF  = 3'd6
  } tl_state_e;

  // Lamp bit positions inside the packed {R,G,Y} vector.
  localparam int unsigned LAMP_R = 2;
  localparam int unsigned LAMP_G = 1;
  localparam int unsigned LAMP_Y = 0;

  // Returns {R,G,Y}; at most one bit is ever set.
  function automatic logic [2:0] lamp_decode(input tl_state_e s);
    logic [2:0] l;
    l = 3'b000;
    case (s)
      GREEN:   l[LAMP_G] = 1'b1;
      BLK_ON:  l[LAMP_G] = 1'b1;
      YELLOW:  l[LAMP_Y] = 1'b1;
      RED:     l[LAMP_R] = 1'b1;
      FL_ON:   l[LAMP_Y] = 1'b1;
      default: l = 3'b000;
    endcase
    return l;
  endfunction

  function automatic logic is_flash_state(input tl_state_e s);
    return (s == FL_ON) || (s == FL_OFF);
  endfunction

endpackage

// File: rtl/traffic_light_param_if.sv
// Signal bundle between the intersection top level (master) and one approach
// controller (slave).
import traffic_light_pkg::*;

// No valid/ready handshake: pass, hold and flash are level requests sampled on
// every rising clk edge; the lamp, phase and remain outputs are valid every cycle.
interface traffic_light_param_if #(
  parameter int CNT_W = 11
) ();
  logic             pass;
  logic             hold;
  logic             flash;
  logic             R;
  logic             G;
  logic             Y;
  logic [2:0]       phase;
  logic [CNT_W-1:0] remain;

  modport master (
    output pass, hold, flash,
    input  R, G, Y, phase, remain
  );

  modport slave (
    input  pass, hold, flash,
    output R, G, Y, phase, remain
  );
endinterface

// File: rtl/traffic_light_param_phase_timer.sv
// Phase down-counter: loads a new duration on phase entry, freezes on hold,
// otherwise counts down and reports done at zero.
import traffic_light_pkg::*;

module phase_timer #(
  parameter int               CNT_W   = 11,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_hold,
  output logic [CNT_W-1:0] o_count,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // The owner always loads when done is seen, so stopping at zero only matters
  // if the owner chooses not to advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_count = r_cnt;
  assign o_done  = (r_cnt == '0);

endmodule

// File: rtl/traffic_light_param.sv
// Single-approach traffic-light controller: green, N blink pairs, yellow, red,
// with pass override, hold freeze and night flashing-yellow mode.
import traffic_light_pkg::*;

module traffic_light_param #(
  parameter int CNT_W    = 11,
  parameter int T_GREEN  = 1024,
  parameter int T_BLINK  = 128,
  parameter int N_BLINK  = 2,
  parameter int T_YELLOW = 512,
  parameter int T_RED    = 1024,
  parameter int T_FLASH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_light_param_if.slave  bus
);

  localparam longint CNT_LIM = (64'd1 << CNT_W);
  localparam int     IDX_W   = (N_BLINK > 0) ? $clog2(N_BLINK + 1) : 1;

  generate
    if (T_GREEN < 1 || T_BLINK < 1 || T_YELLOW < 1 || T_RED < 1 || T_FLASH < 1) begin : g_bad_t
      $error("traffic_light_param: every T_* must be >= 1");
    end
    if (longint'(T_GREEN - 1) >= CNT_LIM || longint'(T_BLINK - 1) >= CNT_LIM ||
        longint'(T_YELLOW - 1) >= CNT_LIM || longint'(T_RED - 1) >= CNT_LIM ||
        longint'(T_FLASH - 1) >= CNT_LIM) begin : g_bad_w
      $error("traffic_light_param: CNT_W too narrow for the longest phase");
    end
    if (N_BLINK < 0) begin : g_bad_n
      $error("traffic_light_param: N_BLINK must be >= 0");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_BLINK  = CNT_W'(T_BLINK - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_RED    = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(T_FLASH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'((N_BLINK > 0) ? N_BLINK - 1 : 0);
  localparam logic             HAS_BLINK = (N_BLINK > 0);

  tl_state_e        r_state;
  logic [IDX_W-1:0] r_idx;

  tl_state_e        w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_hold;
  logic [CNT_W-1:0] w_count;
  logic             w_done;
  logic             w_in_flash;
  logic [2:0]       w_lamps;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_GREEN)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_hold     (w_hold),
    .o_count    (w_count),
    .o_done     (w_done)
  );

  // Next-state and timer control; order of the if-chain is the request priority
  // (reset is handled in the registers themselves).
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_hold      = 1'b0;
    w_in_flash  = is_flash_state(r_state);

    if (bus.flash) begin
      if (!w_in_flash) begin
        w_state_nxt = FL_ON;
        w_load      = 1'b1;
        w_load_val  = LD_FLASH;
        w_idx_nxt   = '0;
      end else if (w_done) begin
        w_state_nxt = (r_state == FL_ON) ? FL_OFF : FL_ON;
        w_load      = 1'b1;
        w_load_val  = LD_FLASH;
      end
    end else if (w_in_flash) begin
      // Leaving night mode always restarts from red.
      w_state_nxt = RED;
      w_load      = 1'b1;
      w_load_val  = LD_RED;
      w_idx_nxt   = '0;
    end else if (bus.pass) begin
      if (r_state != GREEN) begin
        w_state_nxt = GREEN;
        w_load      = 1'b1;
        w_load_val  = LD_GREEN;
        w_idx_nxt   = '0;
      end else if (w_done) begin
        // Pass while already green does not extend it.
        w_state_nxt = HAS_BLINK ? BLK_OFF : YELLOW;
        w_load      = 1'b1;
        w_load_val  = HAS_BLINK ? LD_BLINK : LD_YELLOW;
      end
    end else if (bus.hold) begin
      w_hold = 1'b1;
    end else if (w_done) begin
      w_load = 1'b1;
      case (r_state)
        GREEN: begin
          w_state_nxt = HAS_BLINK ? BLK_OFF : YELLOW;
          w_load_val  = HAS_BLINK ? LD_BLINK : LD_YELLOW;
        end
        BLK_OFF: begin
          w_state_nxt = BLK_ON;
          w_load_val  = LD_BLINK;
        end
        BLK_ON: begin
          if (r_idx < IDX_LAST) begin
            w_state_nxt = BLK_OFF;
            w_load_val  = LD_BLINK;
            w_idx_nxt   = r_idx + IDX_W'(1);
          end else begin
            w_state_nxt = YELLOW;
            w_load_val  = LD_YELLOW;
            w_idx_nxt   = '0;
          end
        end
        YELLOW: begin
          w_state_nxt = RED;
          w_load_val  = LD_RED;
        end
        RED: begin
          w_state_nxt = GREEN;
          w_load_val  = LD_GREEN;
        end
        default: begin
          w_state_nxt = GREEN;
          w_load_val  = LD_GREEN;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= GREEN;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Lamps decode straight from the state register so they change with phase.
  assign w_lamps    = lamp_decode(r_state);
  assign bus.R      = w_lamps[LAMP_R];
  assign bus.G      = w_lamps[LAMP_G];
  assign bus.Y      = w_lamps[LAMP_Y];
  assign bus.phase  = r_state;
  assign bus.remain = w_count;

endmodule

// File: tb/tb_traffic_light_param.sv
// Directed bench for traffic_light_param: one instance with two blink pairs,
// one with no blink, short phase lengths so whole cycles fit in a few hundred clocks.
module tb_traffic_light_param;

  localparam int CW = 4;

  localparam int P_GREEN   = 0;
  localparam int P_BLK_OFF = 1;
  localparam int P_BLK_ON  = 2;
  localparam int P_YELLOW  = 3;
  localparam int P_RED     = 4;
  localparam int P_FL_ON   = 5;
  localparam int P_FL_OFF  = 6;

  localparam logic [2:0] L_R    = 3'b100;
  localparam logic [2:0] L_G    = 3'b010;
  localparam logic [2:0] L_Y    = 3'b001;
  localparam logic [2:0] L_NONE = 3'b000;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_checks;
  int n_errors;

  traffic_light_param_if #(.CNT_W(CW)) if_a ();
  traffic_light_param_if #(.CNT_W(CW)) if_b ();

  traffic_light_param #(
    .CNT_W(CW), .T_GREEN(8), .T_BLINK(2), .N_BLINK(2),
    .T_YELLOW(4), .T_RED(8), .T_FLASH(3)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a.slave)
  );

  traffic_light_param #(
    .CNT_W(CW), .T_GREEN(8), .T_BLINK(2), .N_BLINK(0),
    .T_YELLOW(4), .T_RED(8), .T_FLASH(3)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1, "simulation time limit reached");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_now(input bit sel, input string tag, input int ph, input int rem,
                           input logic [2:0] lamps);
    logic [2:0]    g_ph;
    logic [CW-1:0] g_rem;
    logic [2:0]    g_lamps;
    g_ph    = sel ? if_b.phase  : if_a.phase;
    g_rem   = sel ? if_b.remain : if_a.remain;
    g_lamps = sel ? {if_b.R, if_b.G, if_b.Y} : {if_a.R, if_a.G, if_a.Y};
    check({tag, "_phase"},  32'(g_ph),    32'(ph));
    check({tag, "_remain"}, 32'(g_rem),   32'(rem));
    check({tag, "_lamps"},  32'(g_lamps), 32'(lamps));
  endtask

  // Checks a whole phase from remain=len-1 down to 0, advancing one clock each.
  task automatic run_phase(input bit sel, input string tag, input int ph, input int len,
                           input logic [2:0] lamps);
    for (int r = len - 1; r >= 0; r--) begin
      check_now(sel, tag, ph, r, lamps);
      step();
    end
  endtask

  task automatic run_a_full_blink(input string tag);
    run_phase(0, {tag, "_g"},   P_GREEN,   8, L_G);
    run_phase(0, {tag, "_bo1"}, P_BLK_OFF, 2, L_NONE);
    run_phase(0, {tag, "_bn1"}, P_BLK_ON,  2, L_G);
    run_phase(0, {tag, "_bo2"}, P_BLK_OFF, 2, L_NONE);
    run_phase(0, {tag, "_bn2"}, P_BLK_ON,  2, L_G);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.pass = 1'b0; if_a.hold = 1'b0; if_a.flash = 1'b0;
    if_b.pass = 1'b0; if_b.hold = 1'b0; if_b.flash = 1'b0;
    step();
    rst_b = 1'b0;

    // no-blink instance: G8 Y4 R8, period 20, never a blink phase
    for (int k = 0; k < 2; k++) begin
      run_phase(1, "nb_g", P_GREEN,  8, L_G);
      run_phase(1, "nb_y", P_YELLOW, 4, L_Y);
      run_phase(1, "nb_r", P_RED,    8, L_R);
    end
    check_now(1, "nb_wrap", P_GREEN, 7, L_G);

    // reset state, then one full normal cycle
    check_now(0, "rst", P_GREEN, 7, L_G);
    rst_a = 1'b0;
    run_a_full_blink("c1");
    run_phase(0, "c1_y", P_YELLOW, 4, L_Y);
    run_phase(0, "c1_r", P_RED,    8, L_R);
    check_now(0, "c1_wrap", P_GREEN, 7, L_G);

    // pass pulse in the fourth red cycle
    run_a_full_blink("c2");
    run_phase(0, "c2_y", P_YELLOW, 4, L_Y);
    for (int r = 7; r >= 5; r--) begin
      check_now(0, "c2_r", P_RED, r, L_R);
      step();
    end
    check_now(0, "c2_r3", P_RED, 4, L_R);
    if_a.pass = 1'b1;
    step();
    if_a.pass = 1'b0;
    check_now(0, "pass_red", P_GREEN, 7, L_G);

    // pass held through green does not extend it
    if_a.pass = 1'b1;
    run_phase(0, "pass_g", P_GREEN, 8, L_G);
    if_a.pass = 1'b0;
    check_now(0, "pass_exit", P_BLK_OFF, 1, L_NONE);
    step();
    check_now(0, "pass_bo", P_BLK_OFF, 0, L_NONE);
    step();
    run_phase(0, "c3_bn1", P_BLK_ON,  2, L_G);
    run_phase(0, "c3_bo2", P_BLK_OFF, 2, L_NONE);
    run_phase(0, "c3_bn2", P_BLK_ON,  2, L_G);

    // hold for 5 cycles at yellow remain=2
    check_now(0, "h_y3", P_YELLOW, 3, L_Y);
    step();
    check_now(0, "h_y2", P_YELLOW, 2, L_Y);
    if_a.hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_now(0, "hold", P_YELLOW, 2, L_Y);
    end
    if_a.hold = 1'b0;
    step();
    check_now(0, "h_rel1", P_YELLOW, 1, L_Y);
    step();
    check_now(0, "h_rel0", P_YELLOW, 0, L_Y);
    step();
    check_now(0, "h_red", P_RED, 7, L_R);

    // flash entered from green, pass and hold ignored, exit to red
    run_phase(0, "f_r", P_RED, 8, L_R);
    check_now(0, "f_g7", P_GREEN, 7, L_G);
    step();
    check_now(0, "f_g6", P_GREEN, 6, L_G);
    if_a.flash = 1'b1;
    if_a.pass  = 1'b1;
    if_a.hold  = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      run_phase(0, "fl_on",  P_FL_ON,  3, L_Y);
      run_phase(0, "fl_off", P_FL_OFF, 3, L_NONE);
    end
    check_now(0, "fl_on_last", P_FL_ON, 2, L_Y);
    if_a.flash = 1'b0;
    if_a.pass  = 1'b0;
    if_a.hold  = 1'b0;
    step();
    check_now(0, "fl_exit", P_RED, 7, L_R);

    // reset mid BLK_ON wins over pass and flash; blink index restarts
    run_phase(0, "r6_r",  P_RED,     8, L_R);
    run_phase(0, "r6_g",  P_GREEN,   8, L_G);
    run_phase(0, "r6_bo", P_BLK_OFF, 2, L_NONE);
    check_now(0, "r6_bn", P_BLK_ON, 1, L_G);
    rst_a      = 1'b1;
    if_a.pass  = 1'b1;
    if_a.flash = 1'b1;
    step();
    rst_a      = 1'b0;
    if_a.pass  = 1'b0;
    if_a.flash = 1'b0;
    check_now(0, "r6_rst", P_GREEN, 7, L_G);
    run_a_full_blink("r6c");
    check_now(0, "r6_y", P_YELLOW, 3, L_Y);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
